// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller for the five-stage pipeline.
// It runs the data-memory request/ack handshake and stalls the upstream
// stages while an access is outstanding. It resolves branch/jump redirects
// and owns the MEM/WB pipeline register.
// Optional build macro MEM_TIMEOUT_EN adds a bounded WAIT with a sticky
// mem_timeout flag. Without it, WAIT is held until ack and mem_timeout is 0.
module mem_stage_ctrl #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    // EX/MEM pipeline register outputs
    input  logic [DATA_W-1:0] PC_next_MEM,
    input  logic [DATA_W-1:0] ALU_result_MEM,
    input  logic [DATA_W-1:0] Read_Data_2_MEM,
    input  logic              Branch_MEM,
    input  logic              Jump_MEM,
    input  logic              Zero_MEM,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic              MemToReg_MEM,
    input  logic              RegWrite_MEM,
    input  logic [REG_W-1:0]  Write_register_MEM,
    // data-memory bus
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    // hazard / redirect
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    // MEM/WB pipeline register
    output logic [DATA_W-1:0] Read_data_WB,
    output logic [DATA_W-1:0] ALU_result_WB,
    output logic              MemToReg_WB,
    output logic              RegWrite_WB,
    output logic [REG_W-1:0]  Write_register_WB,
    output logic              mem_timeout
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t r_state;

    logic w_mem_op;
    logic w_timeout_hit;
    logic w_done;
    logic w_stall;

    // A zero-length wait budget would make WAIT meaningless.
    generate
        if (MAX_WAIT < 1) begin : g_bad_max_wait
            $error("MAX_WAIT must be at least 1");
        end
    endgenerate

    assign w_mem_op = MemRead_MEM | MemWrite_MEM;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;

    // The counter reaches MAX_WAIT-1 in the MAX_WAIT-th WAIT cycle. The access
    // is abandoned at the end of that cycle. An ack in that cycle takes priority.
    assign w_timeout_hit = (r_state == S_WAIT) && !dmem_ack &&
                           (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

    // Count un-acked WAIT cycles; latch the sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_wait_cnt <= '0;
            end else if (!dmem_ack) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign mem_timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign mem_timeout   = 1'b0;
`endif

    // The access completes on the ack cycle (or the timeout cycle).
    // EX/MEM may advance on that same edge.
    assign w_done  = (r_state == S_WAIT) && (dmem_ack || w_timeout_hit);

    // An IDLE memory op stalls for its setup cycle. WAIT stalls until done.
    // dmem_ack seen in IDLE has no effect.
    assign w_stall = (r_state == S_IDLE) ? w_mem_op : !w_done;

    // Reset clears stall at once, not at the next clock edge.
    assign stall     = w_stall & ~reset;
    assign pc_src    = ((Branch_MEM & Zero_MEM) | Jump_MEM) & ~stall;
    assign pc_target = PC_next_MEM;

    // Request FSM: launch from IDLE, hold the bus in WAIT until ack/timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_state    <= S_WAIT;
                        dmem_req   <= 1'b1;
                        // If both MemRead and MemWrite are set, the write wins.
                        dmem_we    <= MemWrite_MEM;
                        dmem_addr  <= ALU_result_MEM;
                        dmem_wdata <= Read_Data_2_MEM;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_state  <= S_IDLE;
                        dmem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB register: insert a bubble while stalled, otherwise capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Read_data_WB      <= '0;
            ALU_result_WB     <= '0;
            MemToReg_WB       <= 1'b0;
            RegWrite_WB       <= 1'b0;
            Write_register_WB <= '0;
        end else if (w_stall) begin
            // Only the controls are cleared; the data fields keep their values.
            RegWrite_WB <= 1'b0;
            MemToReg_WB <= 1'b0;
        end else begin
            ALU_result_WB     <= ALU_result_MEM;
            MemToReg_WB       <= MemToReg_MEM;
            RegWrite_WB       <= RegWrite_MEM;
            Write_register_WB <= Write_register_MEM;
            // Load data is captured only for a read acked in WAIT.
            // Writes, timeouts and non-memory ops capture 0.
            if ((r_state == S_WAIT) && dmem_ack && !dmem_we) begin
                Read_data_WB <= dmem_rdata;
            end else begin
                Read_data_WB <= '0;
            end
        end
    end

endmodule
